mcp23s17_spi_master: RTL and testbench
======================================

# mcp23s17_spi_master

- SPI master that runs single-register transactions on the MCP23S17 expander model.
- Drives that model's `clk`, `cs` and `mosi` pins from its `sclk`, `cs` and `mosi` outputs, and samples its `miso`.
- Accepts one host request (read or write, hardware address, register address, data).
- Serialises the 24-bit opcode/address/data frame MSB-first, returns read data and pulses `done` when the frame completes.

## Interface
Parameters:
- `CLK_DIV`, 4: `sclk` half-period in `clk` cycles; legal range ≥1.
- `CS_SETUP`, 2: `clk` cycles with `cs` high before the first `sclk` low phase begins; legal range ≥1.
- `CS_HOLD`, 2: `clk` cycles with `cs` held high after the last `sclk` falling edge; legal range ≥1.
- `CS_IDLE`, 4: minimum `clk` cycles with `cs` low after a frame before `done`; legal range ≥1.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request strobe; sampled only while `busy`=0.
- `rw` input 1: 1=read, 0=write.
- `hw_addr` input 3: device hardware address A2..A0.
- `reg_addr` input 8: register address byte.
- `wdata` input 8: write data byte.
- `busy` output 1: transaction in progress.
- `done` output 1: one-cycle completion pulse.
- `rdata` output 8: data captured by the last read.
- `sclk` output 1: SPI clock; idles low.
- `cs` output 1: chip select, active-high (matches the expander model); idles low.
- `mosi` output 1: serial data out.
- `miso` input 1: serial data in.

## Operation
- **Reset values:** `busy`=0, `done`=0, `rdata`=0x00, `sclk`=0, `cs`=0, `mosi`=0. State is IDLE.
- **Request capture:**
  - `start`=1 with `busy`=0 latches `rw`, `hw_addr`, `reg_addr` and `wdata`.
  - The 24-bit frame is {0100, A2..A0, rw, reg_addr, wdata}.
  - `start` while `busy`=1 is ignored.
- **States:**
  - IDLE: waits for `start`.
  - SETUP: `cs`=1, `sclk`=0, `mosi`=frame bit 23; lasts `CS_SETUP` cycles.
  - SHIFT: 24 bits, each a low phase of `CLK_DIV` cycles followed by a high phase of `CLK_DIV` cycles.
  - HOLD: `sclk`=0, `cs`=1; lasts `CS_HOLD` cycles.
  - GAP: `cs`=0; lasts `CS_IDLE` cycles.
  - DONE: `done`=1 for one cycle, `busy`=0, then IDLE.
- **mosi:** changes only in the `clk` cycle where `sclk` falls, or on SETUP entry, so it is stable for a full half-period around every rising edge.
- **miso:**
  - Sampled into an 8-bit shift register in the `clk` cycle where `sclk` falls (after the slave's rising-edge update).
  - On a read, `rdata` is loaded with the last 8 sampled bits, MSB first, on entry to HOLD.
  - On a write, `rdata` is unchanged.
- **Back-to-back:** `start` in the DONE cycle (`busy`=0) is accepted. There is no idle cycle between frames beyond GAP.
- **Reset mid-frame:** all outputs return to reset values immediately (asynchronous). No `done` is issued. The partial frame is abandoned.

## Timing
- Cycle 0 is the cycle in which `start` is sampled.
- `busy`=1 from cycle 1, and `cs` rises in cycle 1.
- First `sclk` rising edge at cycle 1+`CS_SETUP`+`CLK_DIV`.
- Rising edge k (0..23) at cycle 1+`CS_SETUP`+`CLK_DIV`·(2k+1).
- `cs` falls at cycle 1+`CS_SETUP`+48·`CLK_DIV`+`CS_HOLD`.
- `done`=1 and `busy`=0 at cycle N = 1+`CS_SETUP`+48·`CLK_DIV`+`CS_HOLD`+`CS_IDLE`. With defaults N = 201.
- `rdata` is valid no later than cycle N and holds until the next read completes.
- Bit counter 0..23 and phase counter 0..`CLK_DIV`-1 are sized to the parameters. There is no wrap beyond 24 bits.

## Configuration
- `MCP_SPI_HAEN_EN` defined:
  - Opcode bits 3..1 carry `hw_addr`.
  - Supports several expanders sharing one `cs` with IOCON.HAEN set.
- Not defined:
  - Opcode bits 3..1 are forced to 000 and `hw_addr` is ignored.
  - Frame timing is identical.

## Test plan
- **Write, macro defined:** `hw_addr`=3, `reg_addr`=0x00, `wdata`=0x12, `rw`=0 → `mosi` bits at rising edges = 0x46, 0x00, 0x12; `done` at cycle 201; `rdata` unchanged.
- **Read, macro undefined:** `hw_addr`=5, `reg_addr`=0x09, `rw`=1; slave drives 0xA5 in byte 3 → opcode 0x41 on `mosi`; `rdata`=0xA5 when `done` pulses.
- **Busy rejection:** `start` pulsed at cycles 0 and 50 → exactly one frame; one `done` at cycle 201.
- **Back-to-back:** second `start` in the `done` cycle → second frame's `cs` rises the next cycle; second `done` 201 cycles after the first.
- **Reset mid-frame:** `reset` asserted at cycle 100 → `cs`, `sclk`, `mosi`, `busy`=0 immediately; no `done`; a new `start` after release produces a full correct frame.
- **`CLK_DIV`=1 corner:** `CS_SETUP`=`CS_HOLD`=`CS_IDLE`=1 → `sclk` toggles every cycle; `done` at cycle 52; write of 0xFF to reg 0x15 is decoded correctly by the expander model.

Source files
------------

// File: rtl/mcp23s17_spi_master.sv
// -----------------------------------------------------------------------------
// mcp23s17_spi_master
//
// SPI master running single-register transactions on an MCP23S17 expander.
// One host request is latched and serialised as a 24-bit frame, MSB first:
//   {4'b0100, A2..A0, rw, reg_addr, wdata}
// Read data is returned on rdata, and done pulses when the frame completes.
// cs is active-high to match the expander model. sclk idles low.
//
// Configuration macro: MCP_SPI_HAEN_EN
//   defined   : opcode bits 3..1 carry hw_addr, so several expanders with
//               IOCON.HAEN set can share one cs.
//   undefined : opcode bits 3..1 are forced to 000 and hw_addr is ignored.
//               Frame timing is the same in both builds.
//
// Parameters:
//   CLK_DIV  - sclk half-period in clk cycles (>=1)
//   CS_SETUP - cycles with cs high before the first sclk low phase (>=1)
//   CS_HOLD  - cycles with cs high after the last sclk falling edge (>=1)
//   CS_IDLE  - cycles with cs low after a frame, before done (>=1)
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-low reset
//   start    in   request strobe, sampled only while busy=0
//   rw       in   1=read, 0=write
//   hw_addr  in   [2:0] device hardware address A2..A0
//   reg_addr in   [7:0] register address
//   wdata    in   [7:0] write data
//   busy     out  transaction in progress
//   done     out  one-cycle completion pulse
//   rdata    out  [7:0] data captured by the last read
//   sclk     out  SPI clock
//   cs       out  chip select (active-high)
//   mosi     out  serial data out
//   miso     in   serial data in
// -----------------------------------------------------------------------------
module mcp23s17_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [2:0] hw_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP,
    S_DONE
  } state_t;

  // Phase counter spans 0..CLK_DIV-1. The timer serves SETUP, HOLD and GAP,
  // so it is sized for the longest of the three.
  localparam int PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TMAX = (CS_SETUP > CS_HOLD) ?
                        ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE) :
                        ((CS_HOLD  > CS_IDLE) ? CS_HOLD  : CS_IDLE);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
  localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_HOLD - 1);
  localparam logic [TW-1:0] IDLE_LAST  = TW'(CS_IDLE - 1);
  localparam logic [4:0]    BIT_LAST   = 5'd23;

  state_t          state, state_nxt;
  logic [PW-1:0]   phase, phase_nxt;
  logic [TW-1:0]   tmr, tmr_nxt;
  logic [4:0]      bit_cnt, bit_nxt;
  logic            half, half_nxt;     // 0 = sclk low phase, 1 = high phase
  logic            load;               // latch a new request
  logic            shift_tx;           // sclk falls into the next bit
  logic            sample;             // sclk falls: capture miso
  logic            enter_hold;         // last sclk fall of the frame

  logic [22:0]     tx;                 // frame bits still to be sent
  logic [7:0]      rx;
  logic            rw_q;
  logic [2:0]      addr_bits;
  logic [23:0]     frame;

`ifdef MCP_SPI_HAEN_EN
  assign addr_bits = hw_addr;
`else
  logic unused_hw_addr;
  assign unused_hw_addr = ^hw_addr;
  assign addr_bits      = 3'b000;
`endif

  assign frame = {4'b0100, addr_bits, rw, reg_addr, wdata};

  // NOTE: every signal written here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    tmr_nxt    = tmr;
    bit_nxt    = bit_cnt;
    half_nxt   = half;
    load       = 1'b0;
    shift_tx   = 1'b0;
    sample     = 1'b0;
    enter_hold = 1'b0;

    unique case (state)
      S_IDLE, S_DONE: begin
        // A start in the DONE cycle chains straight into the next frame.
        if (start) begin
          state_nxt = S_SETUP;
          tmr_nxt   = '0;
          load      = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end

      S_SETUP: begin
        if (tmr == SETUP_LAST) begin
          state_nxt = S_SHIFT;
          phase_nxt = '0;
          bit_nxt   = '0;
          half_nxt  = 1'b0;
        end else begin
          tmr_nxt = tmr + TW'(1);
        end
      end

      S_SHIFT: begin
        if (phase == PHASE_LAST) begin
          phase_nxt = '0;
          if (!half) begin
            half_nxt = 1'b1;
          end else begin
            // High phase ends: sclk falls, after the slave has updated miso
            // on the preceding rising edge.
            half_nxt = 1'b0;
            sample   = 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state_nxt  = S_HOLD;
              tmr_nxt    = '0;
              enter_hold = 1'b1;
            end else begin
              bit_nxt  = bit_cnt + 5'd1;
              shift_tx = 1'b1;
            end
          end
        end else begin
          phase_nxt = phase + PW'(1);
        end
      end

      S_HOLD: begin
        if (tmr == HOLD_LAST) begin
          state_nxt = S_GAP;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + TW'(1);
        end
      end

      S_GAP: begin
        if (tmr == IDLE_LAST) begin
          state_nxt = S_DONE;
        end else begin
          tmr_nxt = tmr + TW'(1);
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so they change exactly
  // on clk edges without combinational glitches.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      phase   <= '0;
      tmr     <= '0;
      bit_cnt <= '0;
      half    <= 1'b0;
      tx      <= '0;
      rx      <= '0;
      rw_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      sclk    <= 1'b0;
      cs      <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      tmr     <= tmr_nxt;
      bit_cnt <= bit_nxt;
      half    <= half_nxt;

      busy <= (state_nxt == S_SETUP) || (state_nxt == S_SHIFT) ||
              (state_nxt == S_HOLD)  || (state_nxt == S_GAP);
      cs   <= (state_nxt == S_SETUP) || (state_nxt == S_SHIFT) ||
              (state_nxt == S_HOLD);
      sclk <= (state_nxt == S_SHIFT) && half_nxt;
      done <= (state_nxt == S_DONE);

      // mosi moves only on SETUP entry or on an sclk falling edge.
      if (load) begin
        tx   <= frame[22:0];
        rw_q <= rw;
        mosi <= frame[23];
      end else if (shift_tx) begin
        tx   <= {tx[21:0], 1'b0};
        mosi <= tx[22];
      end else if (enter_hold) begin
        mosi <= 1'b0;
      end

      if (sample) begin
        rx <= {rx[6:0], miso};
      end

      // The final sample lands on the same edge, so include it directly.
      if (enter_hold && rw_q) begin
        rdata <= {rx[6:0], miso};
      end
    end
  end

endmodule

// File: tb/tb_mcp23s17_spi_master.sv
// -----------------------------------------------------------------------------
// tb_mcp23s17_spi_master
//
// Scoreboard bench for mcp23s17_spi_master. Two instances share the clock and
// reset: dut (default timing, N=201) and dut_f (CLK_DIV=1, all cs timings 1,
// N=52). A slave model per instance records mosi at every sclk rising edge and
// drives miso for the data byte of a read. Each accepted request pushes its
// expected frame, done cycle and rdata into a queue; a monitor per instance
// pops and compares whenever done pulses.
// -----------------------------------------------------------------------------
module tb_mcp23s17_spi_master;

  localparam int N_DEF  = 201;
  localparam int N_FAST = 52;

  typedef struct {
    int          done_cyc;
    logic [23:0] frame;
    logic [7:0]  rdata;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_d = 1'b0, start_f = 1'b0;
  logic       rw = 1'b0;
  logic [2:0] hw_addr = '0;
  logic [7:0] reg_addr = '0, wdata = '0;

  logic       busy_d, done_d, sclk_d, cs_d, mosi_d;
  logic       busy_f, done_f, sclk_f, cs_f, mosi_f;
  logic [7:0] rdata_d, rdata_f;
  logic       miso_d = 1'b0, miso_f = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  exp_t q_d[$];
  exp_t q_f[$];
  logic [7:0] last_rd_d = 8'h00, last_rd_f = 8'h00;
  logic [7:0] sb_d = 8'h00, sb_f = 8'h00;     // byte the slave returns

  logic [23:0] cap_d = '0, cap_f = '0;        // mosi seen at sclk rises
  int          ecnt_d = 0, ecnt_f = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mcp23s17_spi_master dut (
    .clk(clk), .reset(reset), .start(start_d), .rw(rw), .hw_addr(hw_addr),
    .reg_addr(reg_addr), .wdata(wdata), .busy(busy_d), .done(done_d),
    .rdata(rdata_d), .sclk(sclk_d), .cs(cs_d), .mosi(mosi_d), .miso(miso_d)
  );

  mcp23s17_spi_master #(
    .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)
  ) dut_f (
    .clk(clk), .reset(reset), .start(start_f), .rw(rw), .hw_addr(hw_addr),
    .reg_addr(reg_addr), .wdata(wdata), .busy(busy_f), .done(done_f),
    .rdata(rdata_f), .sclk(sclk_f), .cs(cs_f), .mosi(mosi_f), .miso(miso_f)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave models: frame restarts on cs rise; data byte driven after the
  // rising edges of bits 16..23 so the master samples it on the next fall.
  always @(posedge cs_d or posedge sclk_d) begin
    if (!sclk_d) begin
      cap_d  = '0;
      ecnt_d = 0;
      miso_d = 1'b0;
    end else begin
      cap_d = {cap_d[22:0], mosi_d};
      if (ecnt_d >= 16 && ecnt_d <= 23) miso_d = sb_d[23 - ecnt_d];
      else                              miso_d = 1'b0;
      ecnt_d++;
    end
  end

  always @(posedge cs_f or posedge sclk_f) begin
    if (!sclk_f) begin
      cap_f  = '0;
      ecnt_f = 0;
      miso_f = 1'b0;
    end else begin
      cap_f = {cap_f[22:0], mosi_f};
      if (ecnt_f >= 16 && ecnt_f <= 23) miso_f = sb_f[23 - ecnt_f];
      else                              miso_f = 1'b0;
      ecnt_f++;
    end
  end

  // Monitors.
  always @(negedge clk) begin
    if (done_d === 1'b1) begin
      check("dut_request_pending_at_done", q_d.size() != 0, 1);
      if (q_d.size() != 0) begin
        exp_t e;
        e = q_d.pop_front();
        check("dut_done_cycle", cyc, e.done_cyc);
        check("dut_mosi_frame", cap_d, e.frame);
        check("dut_sclk_rises", ecnt_d, 24);
        check("dut_rdata", rdata_d, e.rdata);
        check("dut_busy_in_done", busy_d, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (done_f === 1'b1) begin
      check("fast_request_pending_at_done", q_f.size() != 0, 1);
      if (q_f.size() != 0) begin
        exp_t e;
        e = q_f.pop_front();
        check("fast_done_cycle", cyc, e.done_cyc);
        check("fast_mosi_frame", cap_f, e.frame);
        check("fast_sclk_rises", ecnt_f, 24);
        check("fast_rdata", rdata_f, e.rdata);
      end
    end
  end

  function automatic logic [23:0] exp_frame(input logic r, input logic [2:0] hw,
                                            input logic [7:0] ra,
                                            input logic [7:0] wd);
    logic [2:0] a;
`ifdef MCP_SPI_HAEN_EN
    a = hw;
`else
    a = 3'b000;
`endif
    return {4'b0100, a, r, ra, wd};
  endfunction

  // Called at a negedge; drives start for one cycle and returns at the
  // negedge of cycle 1.
  task automatic issue(input bit fast, input logic r, input logic [2:0] hw,
                       input logic [7:0] ra, input logic [7:0] wd,
                       input logic [7:0] sbyte);
    exp_t e;
    rw = r; hw_addr = hw; reg_addr = ra; wdata = wd;
    e.frame = exp_frame(r, hw, ra, wd);
    if (!fast) begin
      sb_d = sbyte;
      if (r) last_rd_d = sbyte;
      e.done_cyc = cyc + N_DEF;
      e.rdata    = last_rd_d;
      q_d.push_back(e);
      start_d = 1'b1;
    end else begin
      sb_f = sbyte;
      if (r) last_rd_f = sbyte;
      e.done_cyc = cyc + N_FAST;
      e.rdata    = last_rd_f;
      q_f.push_back(e);
      start_f = 1'b1;
    end
    @(negedge clk);
    start_d = 1'b0;
    start_f = 1'b0;
  endtask

  task automatic wait_done(input bit fast, input int bound, input string name);
    int n;
    n = 0;
    while (((fast ? done_f : done_d) !== 1'b1) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) check(name, fast ? done_f : done_d, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_busy", busy_d, 0);
    check("rst_done", done_d, 0);
    check("rst_rdata", rdata_d, 8'h00);
    check("rst_sclk", sclk_d, 0);
    check("rst_cs", cs_d, 0);
    check("rst_mosi", mosi_d, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Write hw=3 reg 0x00 data 0x12; rdata stays 0x00.
    issue(0, 1'b0, 3'd3, 8'h00, 8'h12, 8'h00);
    check("busy_cycle1", busy_d, 1);
    check("cs_cycle1", cs_d, 1);
    check("sclk_cycle1", sclk_d, 0);
    check("mosi_bit23_setup", mosi_d, 0);
    wait_done(0, 300, "write_timeout");
    @(negedge clk);

    // Read hw=5 reg 0x09, slave returns 0xA5.
    issue(0, 1'b1, 3'd5, 8'h09, 8'h00, 8'hA5);
    wait_done(0, 300, "read_timeout");
    @(negedge clk);

    // Busy rejection: second start at cycle 50 must be ignored.
    issue(0, 1'b0, 3'd1, 8'h0A, 8'h3C, 8'h00);
    repeat (49) @(negedge clk);
    rw = 1'b1; hw_addr = 3'd6; reg_addr = 8'h77; wdata = 8'hEE;
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    wait_done(0, 300, "reject_timeout");
    repeat (220) @(negedge clk);

    // Back-to-back: second start in the done cycle.
    issue(0, 1'b1, 3'd2, 8'h13, 8'h00, 8'h5A);
    wait_done(0, 300, "b2b_first_timeout");
    issue(0, 1'b0, 3'd7, 8'h14, 8'h81, 8'h00);
    check("b2b_cs_next_cycle", cs_d, 1);
    wait_done(0, 300, "b2b_second_timeout");
    @(negedge clk);

    // Reset mid-frame at cycle 100.
    issue(0, 1'b1, 3'd4, 8'h01, 8'h00, 8'hC3);
    repeat (99) @(negedge clk);
    check("cs_before_reset", cs_d, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_cs", cs_d, 0);
    check("mid_rst_sclk", sclk_d, 0);
    check("mid_rst_mosi", mosi_d, 0);
    check("mid_rst_busy", busy_d, 0);
    check("mid_rst_rdata", rdata_d, 8'h00);
    q_d.delete();
    last_rd_d = 8'h00;
    last_rd_f = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (250) @(negedge clk);
    issue(0, 1'b1, 3'd6, 8'h12, 8'h00, 8'h99);
    wait_done(0, 300, "post_reset_timeout");
    @(negedge clk);

    // CLK_DIV=1 corner: write 0xFF to reg 0x15, then read it back.
    issue(1, 1'b0, 3'd0, 8'h15, 8'hFF, 8'h00);
    check("fast_sclk_setup", sclk_f, 0);
    @(negedge clk);
    check("fast_sclk_low0", sclk_f, 0);
    @(negedge clk);
    check("fast_sclk_high0", sclk_f, 1);
    @(negedge clk);
    check("fast_sclk_low1", sclk_f, 0);
    wait_done(1, 100, "fast_write_timeout");
    @(negedge clk);
    issue(1, 1'b1, 3'd0, 8'h15, 8'h00, 8'h3E);
    wait_done(1, 100, "fast_read_timeout");
    repeat (5) @(negedge clk);

    check("dut_queue_drained", q_d.size(), 0);
    check("fast_queue_drained", q_f.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
